mavg_thresh_det: RTL and testbench
==================================

Name: mavg_thresh_det

Overview:
- Downstream consumer of the 4-sample moving-average stage.
- Takes the smoothed sample stream and raises a debounced alarm with hysteresis when the average crosses a programmable high threshold.
- Drops the alarm only after the average settles below a programmable low threshold.
- Also keeps a saturating alarm-event counter and a running peak of the averaged value, for status readout.

Parameters:
- W, 4, sample width; matches the averager output width.
- DEBOUNCE, 3, consecutive qualifying samples needed to enter or leave alarm; legal range 1..15.
- CNT_W, 8, width of the event counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  y_in is a valid new averaged sample this cycle.
- y_in  input  W  averaged sample from the moving-average stage, unsigned.
- thr_hi  input  W  alarm-entry threshold, unsigned; qualifies when y_in >= thr_hi.
- thr_lo  input  W  alarm-exit threshold, unsigned; qualifies when y_in <= thr_lo.
- clear  input  1  synchronous clear of event_count and peak only.
- alarm  output  1  registered alarm level.
- alarm_pulse  output  1  one-cycle pulse on each alarm rising edge.
- event_count  output  CNT_W  number of alarm entries, saturating.
- peak  output  W  maximum y_in seen on sample_en cycles since reset or clear.

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. Reset forces state IDLE, debounce counter 0, and alarm, alarm_pulse, event_count and peak all 0.
- Reset mid-operation overrides everything, including a pending entry.
- Only cycles with sample_en=1 advance the FSM or the debounce counter. Cycles with sample_en=0 hold all state; y_in is ignored on those cycles.
- Thresholds are sampled on each sample_en cycle; there is no shadowing.
- FSM states: IDLE, PEND_HI, ALARM, PEND_LO.
- IDLE:
  - hi-qualify: with DEBOUNCE=1, go to ALARM; otherwise go to PEND_HI with cnt=1.
  - Otherwise stay in IDLE.
- PEND_HI:
  - hi-qualify: cnt+1. If cnt+1==DEBOUNCE, go to ALARM and clear cnt.
  - Non-qualifying sample: go to IDLE, cnt=0. Consecutive means consecutive valid samples.
- ALARM:
  - lo-qualify: with DEBOUNCE=1, go to IDLE; otherwise go to PEND_LO with cnt=1.
  - Otherwise stay in ALARM.
- PEND_LO:
  - lo-qualify: cnt+1. If cnt+1==DEBOUNCE, go to IDLE and clear cnt.
  - Non-qualifying sample: go to ALARM, cnt=0.
- alarm is 1 in ALARM and PEND_LO, 0 in IDLE and PEND_HI. It is registered: it rises or falls on the clock edge that consumes the final qualifying sample, i.e. it is visible the cycle after that sample is presented.
- alarm_pulse is high for exactly the first cycle alarm is 1 after each entry into ALARM from PEND_HI or IDLE. It is never asserted on a PEND_LO→ALARM return.
- event_count increments on every alarm entry and saturates at 2^CNT_W-1.
- clear zeroes event_count. If clear coincides with an entry, event_count becomes 1.
- peak is updated on sample_en: peak <= max(peak, y_in). clear with sample_en loads peak <= y_in; clear without sample_en loads 0.
- clear does not affect FSM, cnt or alarm.
- Inverted band (thr_lo >= thr_hi) is not an error: the rules above apply literally, and ALARM may exit immediately after debounce.
- Comparisons are unsigned, full W bits. There is no arithmetic overflow path; the debounce counter is 4 bits wide.

Test Plan (DEBOUNCE=3, thr_hi=10, thr_lo=6 unless noted):
- Reset: hold reset 2 cycles with y_in=15, sample_en=1 → alarm=0, alarm_pulse=0, event_count=0, peak=0. After release, a further 2 samples of 15 leave alarm still 0.
- Entry: samples 12,12,12 → alarm=1 the cycle after the 3rd sample; alarm_pulse=1 for that cycle only; event_count=1; peak=12.
- Debounce restart: samples 12,12,9,12,12 → alarm stays 0. One more 12 → alarm=1.
- Hysteresis: in ALARM, 10 samples of 8 → alarm holds 1. Then 6,5,7,6,6,6 → alarm holds through the 7 (PEND_LO abort); alarm=0 after the final three 6s. No alarm_pulse during the sequence.
- Gaps: 12, then 5 cycles sample_en=0 with y_in=0, then 12,12 → alarm=1; peak stays 12.
- Saturation/clear (CNT_W=2):
  - 4 alarm entries → event_count=3 and holds.
  - clear in the same cycle as the 5th entry → event_count=1.
  - reset asserted in PEND_HI → IDLE; next two 12s give no alarm.

Source files
------------

// File: rtl/mavg_thresh_det.sv
// Debounced hysteresis alarm on the smoothed sample stream from the 4-sample
// moving-average stage. Also keeps a saturating count of alarm entries and
// a running peak of the averaged value for status readout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no alarm, no high-qualifying samples pending
//   PEND_HI | no alarm yet, counting consecutive samples >= thr_hi
//   ALARM   | alarm asserted, no low-qualifying samples pending
//   PEND_LO | alarm still asserted, counting consecutive samples <= thr_lo
module mavg_thresh_det #(
    parameter int W        = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [W-1:0]     y_in,
    input  logic [W-1:0]     thr_hi,
    input  logic [W-1:0]     thr_lo,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic [W-1:0]     peak
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PEND_HI = 2'd1;
    localparam logic [1:0] S_ALARM   = 2'd2;
    localparam logic [1:0] S_PEND_LO = 2'd3;

    localparam logic [3:0]       DB      = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] EVT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_inc;
    logic             alarm_q, alarm_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [W-1:0]     peak_q, peak_d;
    logic             hi_qual, lo_qual;
    logic             entry;

    assign hi_qual = (y_in >= thr_hi);
    assign lo_qual = (y_in <= thr_lo);
    assign cnt_inc = cnt_q + 4'd1;

    // Next-state / debounce counter; only valid samples advance anything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        entry   = 1'b0;
        if (sample_en) begin
            case (state_q)
                S_IDLE: begin
                    if (hi_qual) begin
                        if (DB == 4'd1) begin
                            state_d = S_ALARM;
                            entry   = 1'b1;
                        end else begin
                            state_d = S_PEND_HI;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_PEND_HI: begin
                    if (hi_qual) begin
                        if (cnt_inc == DB) begin
                            state_d = S_ALARM;
                            cnt_d   = 4'd0;
                            entry   = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_ALARM: begin
                    if (lo_qual) begin
                        if (DB == 4'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_PEND_LO;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_PEND_LO: begin
                    if (lo_qual) begin
                        if (cnt_inc == DB) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // abort exit: back to ALARM without a new entry event
                        state_d = S_ALARM;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Outputs derived from the next state so they change on the consuming edge.
    always_comb begin
        alarm_d = (state_d == S_ALARM) || (state_d == S_PEND_LO);
        pulse_d = entry;
    end

    // Status: saturating entry counter and running peak, both clearable.
    always_comb begin
        evt_d  = evt_q;
        peak_d = peak_q;
        if (clear) begin
            evt_d  = entry ? CNT_W'(1) : '0;
            peak_d = sample_en ? y_in : '0;
        end else begin
            if (entry && (evt_q != EVT_MAX)) begin
                evt_d = evt_q + CNT_W'(1);
            end
            if (sample_en && (y_in > peak_q)) begin
                peak_d = y_in;
            end
        end
    end

    // Register update; synchronous reset overrides everything, including a pending entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            alarm_q <= 1'b0;
            pulse_q <= 1'b0;
            evt_q   <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            pulse_q <= pulse_d;
            evt_q   <= evt_d;
            peak_q  <= peak_d;
        end
    end

    assign alarm       = alarm_q;
    assign alarm_pulse = pulse_q;
    assign event_count = evt_q;
    assign peak        = peak_q;

endmodule

// File: tb/tb_mavg_thresh_det.sv
// Bench for mavg_thresh_det: two instances share all inputs, one with
// DEBOUNCE=3/CNT_W=2 and one with DEBOUNCE=1/CNT_W=8. A run-length model of
// the alarm rules predicts every output after every clock.
module tb_mavg_thresh_det;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [3:0] y_in;
    logic [3:0] thr_hi;
    logic [3:0] thr_lo;
    logic       clear;

    logic       alarm0, pulse0;
    logic [1:0] evt0;
    logic [3:0] peak0;
    logic       alarm1, pulse1;
    logic [7:0] evt1;
    logic [3:0] peak1;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = DEBOUNCE 3 / CNT_W 2, index 1 = DEBOUNCE 1 / CNT_W 8
    int         m_db  [2] = '{3, 1};
    int         m_max [2] = '{3, 255};
    bit         m_alarm [2];
    int         m_run   [2];
    bit         m_pulse [2];
    int         m_evt   [2];
    int         m_peak;

    always #5 clk = ~clk;

    mavg_thresh_det #(.W(4), .DEBOUNCE(3), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .y_in(y_in),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(alarm0), .alarm_pulse(pulse0), .event_count(evt0), .peak(peak0)
    );

    mavg_thresh_det #(.W(4), .DEBOUNCE(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .y_in(y_in),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(alarm1), .alarm_pulse(pulse1), .event_count(evt1), .peak(peak1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit se, input int y, input bit clr);
        bit ent;
        for (int i = 0; i < 2; i++) begin
            ent = 1'b0;
            if (rst) begin
                m_alarm[i] = 1'b0;
                m_run[i]   = 0;
                m_evt[i]   = 0;
            end else begin
                if (se) begin
                    if (!m_alarm[i]) begin
                        m_run[i] = (y >= int'(thr_hi)) ? m_run[i] + 1 : 0;
                        if (m_run[i] == m_db[i]) begin
                            m_alarm[i] = 1'b1;
                            m_run[i]   = 0;
                            ent        = 1'b1;
                        end
                    end else begin
                        m_run[i] = (y <= int'(thr_lo)) ? m_run[i] + 1 : 0;
                        if (m_run[i] == m_db[i]) begin
                            m_alarm[i] = 1'b0;
                            m_run[i]   = 0;
                        end
                    end
                end
                if (clr)                          m_evt[i] = ent ? 1 : 0;
                else if (ent && m_evt[i] < m_max[i]) m_evt[i] = m_evt[i] + 1;
            end
            m_pulse[i] = ent;
        end
        if (rst)                     m_peak = 0;
        else if (clr)                m_peak = se ? y : 0;
        else if (se && y > m_peak)   m_peak = y;
    endtask

    task automatic check_all();
        chk("alarm_d3", 32'(alarm0), 32'(m_alarm[0]));
        chk("pulse_d3", 32'(pulse0), 32'(m_pulse[0]));
        chk("evt_d3",   32'(evt0),   32'(m_evt[0]));
        chk("peak_d3",  32'(peak0),  32'(m_peak));
        chk("alarm_d1", 32'(alarm1), 32'(m_alarm[1]));
        chk("pulse_d1", 32'(pulse1), 32'(m_pulse[1]));
        chk("evt_d1",   32'(evt1),   32'(m_evt[1]));
        chk("peak_d1",  32'(peak1),  32'(m_peak));
    endtask

    // one clock: drive, clock, update model, check #1 after the edge
    task automatic cyc(input bit rst, input bit se, input int y, input bit clr);
        reset     = rst;
        sample_en = se;
        y_in      = 4'(y);
        clear     = clr;
        @(posedge clk);
        model_update(rst, se, y, clr);
        #1;
        check_all();
    endtask

    task automatic samp(input int y);
        cyc(1'b0, 1'b1, y, 1'b0);
    endtask

    task automatic exit_alarm();
        samp(6); samp(6); samp(6);
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; y_in = '0; clear = 1'b0;
        thr_hi = 4'd10; thr_lo = 4'd6;

        // reset held with live samples
        cyc(1'b1, 1'b1, 15, 1'b0);
        cyc(1'b1, 1'b1, 15, 1'b0);
        chk("rst_alarm", 32'(alarm0), 32'd0);
        chk("rst_pulse", 32'(pulse0), 32'd0);
        chk("rst_evt",   32'(evt0),   32'd0);
        chk("rst_peak",  32'(peak0),  32'd0);
        samp(15); samp(15);
        chk("post_rst_alarm", 32'(alarm0), 32'd0);

        // entry
        cyc(1'b1, 1'b0, 0, 1'b0);
        samp(12); samp(12);
        chk("entry_pre", 32'(alarm0), 32'd0);
        samp(12);
        chk("entry_alarm", 32'(alarm0), 32'd1);
        chk("entry_pulse", 32'(pulse0), 32'd1);
        chk("entry_evt",   32'(evt0),   32'd1);
        chk("entry_peak",  32'(peak0),  32'd12);
        cyc(1'b0, 1'b0, 0, 1'b0);
        chk("pulse_one_cycle", 32'(pulse0), 32'd0);
        chk("alarm_held",      32'(alarm0), 32'd1);

        // debounce restart
        exit_alarm();
        chk("exit_alarm", 32'(alarm0), 32'd0);
        samp(12); samp(12); samp(9); samp(12); samp(12);
        chk("restart_no_alarm", 32'(alarm0), 32'd0);
        samp(12);
        chk("restart_alarm", 32'(alarm0), 32'd1);

        // hysteresis with a PEND_LO abort
        for (int i = 0; i < 10; i++) samp(8);
        chk("hyst_hold", 32'(alarm0), 32'd1);
        samp(6); samp(5); samp(7);
        chk("abort_hold", 32'(alarm0), 32'd1);
        chk("abort_no_pulse", 32'(pulse0), 32'd0);
        samp(6); samp(6);
        chk("lo_pend_hold", 32'(alarm0), 32'd1);
        samp(6);
        chk("hyst_exit", 32'(alarm0), 32'd0);

        // gaps between valid samples
        samp(12);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 0, 1'b0);
        samp(12); samp(12);
        chk("gap_alarm", 32'(alarm0), 32'd1);
        chk("gap_peak",  32'(peak0),  32'd12);
        chk("gap_evt",   32'(evt0),   32'd3);

        // saturation then clear on an entry
        exit_alarm();
        samp(12); samp(12); samp(12);
        chk("sat_evt", 32'(evt0), 32'd3);
        exit_alarm();
        samp(12); samp(12);
        cyc(1'b0, 1'b1, 12, 1'b1);
        chk("clear_entry_evt", 32'(evt0), 32'd1);
        chk("clear_peak",      32'(peak0), 32'd12);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("clear_idle_peak", 32'(peak0), 32'd0);

        // reset in PEND_HI
        exit_alarm();
        samp(12);
        cyc(1'b1, 1'b0, 0, 1'b0);
        samp(12); samp(12);
        chk("rst_pend_no_alarm", 32'(alarm0), 32'd0);

        // randomized traffic, occasional threshold changes (inverted band allowed)
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                thr_hi = 4'($urandom_range(0, 15));
                thr_lo = 4'($urandom_range(0, 15));
            end
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
